// File: rtl/jk_counter.sv
// jk_counter: per-bit JK register / up-down counter / loader with wrap pulse; define JK_COUNTER_SAT_EN for saturating counts
module jk_counter #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             wrap
);
  logic [WIDTH-1:0] q_nx;
  logic             at_top, at_bot;
  assign at_top = &q;
  assign at_bot = ~|q;
  assign qb = ~q;
  assign tc = (mode == 2'b01 && at_top) || (mode == 2'b10 && at_bot);
  // next q: JK per bit, count step, or parallel load
  always_comb begin
`ifdef JK_COUNTER_SAT_EN
    q_nx = mode == 2'b00 ? (q & ~k) | (~q & j) :
           mode == 2'b01 ? (at_top ? q : q + 1'b1) :
           mode == 2'b10 ? (at_bot ? q : q - 1'b1) : din;
`else
    q_nx = mode == 2'b00 ? (q & ~k) | (~q & j) :
           mode == 2'b01 ? q + 1'b1 :
           mode == 2'b10 ? q - 1'b1 : din;
`endif
  end
  // state register; wrap flags a count edge taken while tc was high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q    <= RST_VAL;
      wrap <= 1'b0;
    end else if (en) begin
      q    <= q_nx;
`ifdef JK_COUNTER_SAT_EN
      wrap <= 1'b0;
`else
      wrap <= tc;
`endif
    end else begin
      wrap <= 1'b0;
    end
  end
endmodule

// File: tb/tb_jk_counter.sv
// tb_jk_counter: random and directed checks of jk_counter against an arithmetic model
module tb_jk_counter;
  localparam int W = 4;
  localparam int M = (1 << W) - 1;
  logic clk = 0, rst = 0, en = 0;
  logic [1:0] mode = 0;
  logic [W-1:0] j = 0, k = 0, din = 0;
  logic [W-1:0] q, qb;
  logic tc, wrap;
  int total = 0, bad = 0;
  int mq = 0, mw = 0;
  jk_counter #(.WIDTH(W), .RST_VAL('0)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .din(din),
    .q(q), .qb(qb), .tc(tc), .wrap(wrap)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int mtc();
    return ((mode == 2'b01 && mq == M) || (mode == 2'b10 && mq == 0)) ? 1 : 0;
  endfunction
  task automatic check_all(input string tag);
    chk({tag, ".q"}, 32'(q), mq);
    chk({tag, ".qb"}, 32'(qb), M - mq);
    chk({tag, ".wrap"}, 32'(wrap), mw);
    chk({tag, ".tc"}, 32'(tc), mtc());
  endtask
  task automatic step(input string tag);
    int t, nq;
    @(posedge clk);
    if (en) begin
      t = mtc();
      nq = 0;
      case (mode)
        2'b00: for (int b = 0; b < W; b++) begin
          int qb_i;
          qb_i = (mq >> b) & 1;
          if (j[b] && k[b]) qb_i = 1 - qb_i;
          else if (j[b]) qb_i = 1;
          else if (k[b]) qb_i = 0;
          nq += qb_i << b;
        end
`ifdef JK_COUNTER_SAT_EN
        2'b01: nq = (mq == M) ? M : mq + 1;
        2'b10: nq = (mq == 0) ? 0 : mq - 1;
`else
        2'b01: nq = (mq + 1) % (M + 1);
        2'b10: nq = (mq + M) % (M + 1);
`endif
        default: nq = int'(din);
      endcase
      mq = nq;
`ifdef JK_COUNTER_SAT_EN
      mw = 0;
`else
      mw = t;
`endif
    end else mw = 0;
    #1;
    check_all(tag);
  endtask
  task automatic load(input int v);
    en = 1; mode = 2'b11; din = W'(v);
    step("load");
  endtask
  task automatic async_rst();
    #2 rst = 0;
    #1 mq = 0; mw = 0;
    check_all("arst");
    #1 rst = 1;
  endtask
  initial begin
    #3;
    check_all("rst_hold");
    #7 rst = 1;
    step("idle0");
    step("idle1");
    load(3);
    mode = 2'b00; j = 4'b1010; k = 4'b0110;
    step("jk");
    chk("jk_direct", 32'(q), 9);
    en = 0;
    step("jk_hold");
    load(14);
    mode = 2'b01;
    step("up1");
    step("up2");
    step("up3");
    load(1);
    mode = 2'b10;
    step("dn1");
    step("dn2");
    step("dn3");
    load(5);
    chk("ld5", 32'(q), 5);
    mode = 2'b01;
    step("ld_up");
    chk("ld_up6", 32'(q), 6);
    load(7);
    mode = 2'b01;
    step("up8");
    async_rst();
    step("resume");
    load(15);
    mode = 2'b01;
    async_rst();
    step("no_wrap");
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 3) != 0);
      mode = 2'($urandom);
      j = W'($urandom);
      k = W'($urandom);
      din = W'($urandom);
      if ($urandom_range(0, 40) == 0) async_rst();
      step("rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jk_counter.md
JK_COUNTER -- requirements
Module: jk_counter

Interface
REQ-001 Parameter WIDTH, default 4: bit width of the register, counter and all vector ports; legal range 2..32.
REQ-002 Parameter RST_VAL, default 0: value loaded into q by reset; width WIDTH.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately, independent of clk.
REQ-005 en  input  1  update enable; 0 = hold all state.
REQ-006 mode  input  2  operation select: 00 JK-direct, 01 count-up, 10 count-down, 11 load.
REQ-007 j  input  WIDTH  per-bit J inputs, used only in JK-direct mode.
REQ-008 k  input  WIDTH  per-bit K inputs, used only in JK-direct mode.
REQ-009 din  input  WIDTH  parallel load data, used only in load mode.
REQ-010 q  output  WIDTH  registered state.
REQ-011 qb  output  WIDTH  bitwise complement of q at all times, including during reset.
REQ-012 tc  output  1  combinational terminal count: 1 when mode=01 and q=all-ones, or mode=10 and q=0; otherwise 0.
REQ-013 wrap  output  1  registered one-cycle pulse: 1 in the cycle after a count step that rolled over (all-ones->0 up, 0->all-ones down).

Function
REQ-014 en=0: q and wrap hold their values, except that wrap clears to 0 on the first edge with en=0; mode, j, k and din are ignored.
REQ-015 JK-direct, per bit i, on the edge: (j,k)=00 hold, 01 clear to 0, 10 set to 1, 11 toggle; each bit is independent.
REQ-016 Count-up: q <= q+1 modulo 2^WIDTH; Count-down: q <= q-1 modulo 2^WIDTH; one step per enabled edge; zero latency beyond the edge.
REQ-017 Load: q <= din on the edge; din is visible on q in the same cycle as the edge.
REQ-018 wrap <= 1 only on an enabled count edge where tc=1 before the edge; every other enabled edge sets wrap <= 0.
REQ-019 A mode change takes effect on the next edge with no pipeline flush; the first edge in the new mode applies the new operation to the current q.
REQ-020 tc responds combinationally to mode and q; in modes 00 and 11 tc=0.
REQ-021 There are no X-propagation paths from unused inputs: j, k and din in unselected modes do not affect q.

Reset
REQ-022 rst=0 asynchronously sets q=RST_VAL, qb=~RST_VAL and wrap=0; tc follows REQ-012 for the reset value.
REQ-023 Deassertion of rst takes effect at the next rising clk edge; rst asserted mid-count abandons the count with no residual wrap pulse.
REQ-024 Reset has priority over en and every mode.

Configuration
REQ-025 Macro JK_COUNTER_SAT_EN is defined: count-up stops at all-ones and count-down stops at 0; a step at the limit holds q; wrap is tied to 0; tc still flags the limit.
REQ-026 Macro JK_COUNTER_SAT_EN is undefined: counting wraps modulo 2^WIDTH per REQ-016 and REQ-018.

Verification
REQ-027 WIDTH=4, rst=0 for 10 ns, then release -> q=0000 and qb=1111 while rst=0, and q holds until the first enabled edge.
REQ-028 mode=00 with j=1010, k=0110 from q=0011 -> one edge gives q=1001 (bit3 set, bit2 clear, bit1 toggle, bit0 hold); en=0 on the next edge -> q stays 1001.
REQ-029 mode=01 from q=1110 -> edges give 1111 with tc=1, then 0000 with wrap=1 for exactly one cycle; with JK_COUNTER_SAT_EN, q stays 1111 and wrap=0.
REQ-030 mode=10 from q=0001 -> edges give 0000 with tc=1, then 1111 with wrap=1; with JK_COUNTER_SAT_EN, q stays 0000.
REQ-031 mode=11 with din=0101, then mode=01 on the next edge -> q=0101 then q=0110, with no lost or extra step.
REQ-032 rst pulsed low between edges while counting at q=0111 -> q=RST_VAL immediately, asynchronous to clk, with wrap=0; counting resumes from RST_VAL after release.
